muldiv_ctrl: RTL

Multi-cycle multiply/divide sequencer for the MIPS execute stage. It accepts MULT/MULTU/DIV/DIVU requests after the ALU decoder has classified them. It runs an iterative shift-add multiplier and a restoring divider, stalls the pipeline while busy, and presents a 64-bit HI/LO result with a one-cycle done pulse. The HI/LO register write and the MFHI/MFLO/MTHI/MTLO paths live outside this block.

---
 rtl/muldiv_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - MIPS multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO result
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiply instead of shift-add)
module muldiv_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cancel_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   // multiply: {hi, lo/multiplier}; divide: {remainder, quotient/dividend}
   logic [63:0] acc_q, acc_d;
   // multiplicand or divisor
   logic [31:0] opd_q, opd_d;
   logic        div_q, div_d;
   logic        nq_q, nq_d;
   logic        nr_q, nr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
`ifdef MULDIV_FAST_MUL_EN
   logic        sgn_q, sgn_d;
   logic [63:0] fast_a, fast_b, fast_prod;
`else
   logic [32:0] mul_sum;
`endif

   logic        signed_op;
   logic [31:0] a_abs, b_abs;
   logic [32:0] div_rem;
   logic        div_ok;
   logic [31:0] div_diff;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix;
   logic [31:0] res_hi, res_lo;

   assign signed_op = ~op_i[0];
   assign a_abs     = (signed_op && a_i[31]) ? (~a_i + 32'd1) : a_i;
   assign b_abs     = (signed_op && b_i[31]) ? (~b_i + 32'd1) : b_i;

`ifdef MULDIV_FAST_MUL_EN
   assign fast_a    = {{32{sgn_q & opd_q[31]}}, opd_q};
   assign fast_b    = {{32{sgn_q & acc_q[31]}}, acc_q[31:0]};
   assign fast_prod = fast_a * fast_b;
`else
   assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
`endif

   // remainder is always below the divisor, so the wrapped 32-bit difference is exact when div_ok
   assign div_rem   = acc_q[63:31];
   assign div_ok    = (div_rem >= {1'b0, opd_q});
   assign div_diff  = div_rem[31:0] - opd_q;

   assign prod_fix  = nq_q ? (~acc_q + 64'd1) : acc_q;
   assign quot_fix  = nq_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
   assign rem_fix   = nr_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
   assign res_hi    = div_q ? rem_fix  : prod_fix[63:32];
   assign res_lo    = div_q ? quot_fix : prod_fix[31:0];

   // stall is forced low while in reset so every output reads zero
   assign stall_o   = resetn & (((state_q == IDLE) & start_i & ~cancel_i) |
                                (state_q == MUL) | (state_q == DIV));
   assign done_o    = (state_q == DONE) & ~cancel_i;
   assign hi_o      = done_o ? res_hi : hi_q;
   assign lo_o      = done_o ? res_lo : lo_q;

   // next-state and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opd_d   = opd_q;
      div_d   = div_q;
      nq_d    = nq_q;
      nr_d    = nr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef MULDIV_FAST_MUL_EN
      sgn_d   = sgn_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i && !cancel_i) begin
               cnt_d = 6'd0;
               div_d = op_i[1];
               nq_d  = signed_op & (a_i[31] ^ b_i[31]);
               nr_d  = signed_op & a_i[31];
               if (op_i[1]) begin
                  opd_d = b_abs;
                  acc_d = {32'd0, a_abs};
                  if (b_i == 32'd0) begin
                     // divide by zero: raw dividend in HI, all-ones quotient, no fix-up
                     acc_d   = {a_i, 32'hFFFF_FFFF};
                     nq_d    = 1'b0;
                     nr_d    = 1'b0;
                     state_d = DONE;
                  end else begin
                     state_d = DIV;
                  end
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  opd_d = a_i;
                  acc_d = {32'd0, b_i};
                  sgn_d = signed_op;
                  nq_d  = 1'b0;
`else
                  opd_d = a_abs;
                  acc_d = {32'd0, b_abs};
`endif
                  state_d = MUL;
               end
            end
         end
         MUL: begin
            if (cancel_i) begin
               state_d = IDLE;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
               acc_d   = fast_prod;
               state_d = DONE;
`else
               acc_d = {mul_sum, acc_q[31:1]};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) state_d = DONE;
`endif
            end
         end
         DIV: begin
            if (cancel_i) begin
               state_d = IDLE;
            end else begin
               if (div_ok) acc_d = {div_diff, acc_q[30:0], 1'b1};
               else        acc_d = {acc_q[62:0], 1'b0};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) state_d = DONE;
            end
         end
         DONE: begin
            if (!cancel_i) begin
               hi_d = res_hi;
               lo_d = res_lo;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         acc_q   <= 64'd0;
         opd_q   <= 32'd0;
         div_q   <= 1'b0;
         nq_q    <= 1'b0;
         nr_q    <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
`ifdef MULDIV_FAST_MUL_EN
         sgn_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opd_q   <= opd_d;
         div_q   <= div_d;
         nq_q    <= nq_d;
         nr_q    <= nr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef MULDIV_FAST_MUL_EN
         sgn_q   <= sgn_d;
`endif
      end
   end

endmodule
